serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 33 +++
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB first, one bit per clock.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow flag.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder cell on the current LSBs and the registered carry
  logic fa_sum;
  logic fa_carry;
  assign fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: publish the whole result at once so partial sums never show
        if (cnt_q == LAST) begin
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_carry;
`endif
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, handshake corner cases, random ops vs arithmetic model.
module tb_serial_adder;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: verifies latency, busy length, result and the single-cycle done pulse
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec, input logic eo);
    int n;
    int bc;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    step();
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.cin   = 1'($urandom);
    n  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) bc++;
      step();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(WIDTH));
    check({tag, " busy_cycles"}, 32'(bc), 32'(WIDTH));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'(0));
    check({tag, " sum"}, 32'(bus.sum), 32'(es));
    check({tag, " cout"}, 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
    step();
    check({tag, " done_pulse_width"}, 32'(bus.done), 32'(0));
  endtask

  initial begin
    logic [8:0] t;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic       rovf;
    int         pulses;
    int         prev;

    checks = 0;
    errors = 0;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 8'h10, b: 8'h20, cin: 1'b0, sum: 8'h30, cout: 1'b0, ovf: 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) step();
    check("reset busy", 32'(bus.busy), 32'(0));
    check("reset done", 32'(bus.done), 32'(0));
    check("reset sum", 32'(bus.sum), 32'(0));
    check("reset cout", 32'(bus.cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("reset ovf", 32'(bus.ovf), 32'(0));
`endif
    rst_n = 1'b1;
    step();
    check("idle no done", 32'(bus.done), 32'(0));

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // start while busy is ignored: no recapture, no restart, one done pulse
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    step();
    bus.start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= WIDTH + 6; c++) begin
      if (c == 3) begin bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1; end
      if (c == 5) bus.start = 1'b0;
      step();
      if (bus.done === 1'b1) begin
        pulses++;
        check("ignore latency", 32'(c), 32'(WIDTH));
        check("ignore sum", 32'(bus.sum), 32'(8'h30));
        check("ignore cout", 32'(bus.cout), 32'(0));
      end
    end
    check("ignore done count", 32'(pulses), 32'(1));

    // asynchronous reset mid-RUN aborts the operation
    bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    check("abort busy before", 32'(bus.busy), 32'(1));
    #3 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'(0));
    check("abort done", 32'(bus.done), 32'(0));
    check("abort sum", 32'(bus.sum), 32'(0));
    check("abort cout", 32'(bus.cout), 32'(0));
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    check("abort no done", 32'(pulses), 32'(0));
    check("abort sum held", 32'(bus.sum), 32'(0));

    // start held high: completions every WIDTH+2 cycles, sum stable between
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
    pulses = 0;
    prev   = -1;
    for (int c = 0; c < 45; c++) begin
      step();
      if (bus.done === 1'b1) begin
        check("b2b sum", 32'(bus.sum), 32'(8'h03));
        if (prev >= 0) check("b2b spacing", 32'(c - prev), 32'(WIDTH + 2));
        prev = c;
        pulses++;
      end else if (pulses > 0) begin
        check("b2b sum stable", 32'(bus.sum), 32'(8'h03));
      end
    end
    check("b2b pulses", 32'(pulses), 32'(4));
    bus.start = 1'b0;
    repeat (WIDTH + 4) step();

    // random operands against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      t    = 9'(ra) + 9'(rb) + 9'(rc);
      rovf = (ra[7] == rb[7]) && (t[7] != ra[7]);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, t[7:0], t[8], rovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end
endmodule
